// File: rtl/graphic_mem_arbiter.sv
// ---------------------------------------------------------------------------
// graphic_mem_arbiter
//
// Shares the graphic subsystem's single DDR3 controller user port between the
// display scan-out reader (read bursts, high priority) and the AHB frame-buffer
// writer (write bursts). One memory command is issued per 128-bit beat and the
// command address advances by 8 words (one BL8 x16 burst) per accepted beat.
// A saturating counter bounds how many read grants may overtake a pending
// write.
//
// Ports:
//   hclk, hreset            clock (rising edge), asynchronous active-high reset
//   rd_req/rd_addr/rd_len   read burst request (len = beats-1, addr 8-aligned)
//   rd_gnt, rd_done         read burst owns the port / last command accepted
//   rd_valid, rd_data       read return, passed straight from the controller
//   wr_req/wr_addr/wr_len   write burst request (len = beats-1, addr 8-aligned)
//   wr_data, wr_data_ack    write beat in / beat consumed
//   wr_gnt, wr_done         write burst owns the port / last beat accepted
//   mem_cmd_en/mem_cmd/mem_addr/mem_cmd_rdy   controller command channel
//   mem_wr_en/mem_wr_data/mem_wr_rdy          controller write data channel
//   mem_rd_valid/mem_rd_data                  controller read return
// ---------------------------------------------------------------------------
module graphic_mem_arbiter #(
    parameter int ADDR_W     = 27,
    parameter int DATA_W     = 128,
    parameter int LEN_W      = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic              hclk,
    input  logic              hreset,

    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_gnt,
    output logic              rd_done,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,

    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              wr_done,
    output logic              wr_data_ack,

    output logic              mem_cmd_en,
    output logic [2:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_cmd_rdy,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_rdy,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0]   BEAT_STRIDE  = ADDR_W'(8);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [LEN_W-1:0]    beat_cnt, beat_cnt_nxt;
    logic [STARVE_W-1:0] starve_cnt, starve_nxt;

    logic fire;         // current beat accepted by the controller
    logic last_beat;
    logic starve_full;
    logic grant_rd;
    logic grant_wr;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values computed by the combinational block below.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state      <= IDLE;
            addr_q     <= '0;
            beat_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            addr_q     <= addr_nxt;
            beat_cnt   <= beat_cnt_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state, arbitration and firing strobes
    // -----------------------------------------------------------------------
    assign last_beat   = (beat_cnt == '0);
    assign starve_full = (starve_cnt == STARVE_LIMIT);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt    = state;
        addr_nxt     = addr_q;
        beat_cnt_nxt = beat_cnt;
        starve_nxt   = starve_cnt;
        fire         = 1'b0;
        grant_rd     = 1'b0;
        grant_wr     = 1'b0;
        mem_cmd_en   = 1'b0;
        mem_wr_en    = 1'b0;
        wr_data_ack  = 1'b0;
        rd_done      = 1'b0;
        wr_done      = 1'b0;

        case (state)
            IDLE: begin
                // Reads win unless the writer has been passed over
                // STARVE_MAX times in a row.
                grant_wr = wr_req && (!rd_req || starve_full);
                grant_rd = rd_req && !grant_wr;

                if (grant_rd) begin
                    state_nxt    = RD_BURST;
                    addr_nxt     = rd_addr;
                    beat_cnt_nxt = rd_len;
                    // Only a read that overtakes a waiting write counts.
                    if (wr_req && !starve_full)
                        starve_nxt = starve_cnt + STARVE_W'(1);
                end else if (grant_wr) begin
                    state_nxt    = WR_BURST;
                    addr_nxt     = wr_addr;
                    beat_cnt_nxt = wr_len;
                    starve_nxt   = '0;
                end
            end

            RD_BURST: begin
                // Command stays asserted until the controller takes it.
                mem_cmd_en = 1'b1;
                fire       = mem_cmd_rdy;
            end

            WR_BURST: begin
                // Command and data move together or not at all, so the
                // controller never sees a command without its data beat.
                fire        = mem_cmd_rdy && mem_wr_rdy;
                mem_cmd_en  = fire;
                mem_wr_en   = fire;
                wr_data_ack = fire;
            end

            default: state_nxt = IDLE;
        endcase

        if (fire) begin
            addr_nxt = addr_q + BEAT_STRIDE;    // wraps modulo 2^ADDR_W
            if (last_beat) begin
                state_nxt = IDLE;
                rd_done   = (state == RD_BURST);
                wr_done   = (state == WR_BURST);
            end else begin
                beat_cnt_nxt = beat_cnt - LEN_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered decodes and passthroughs
    // -----------------------------------------------------------------------
    assign rd_gnt      = (state == RD_BURST);
    assign wr_gnt      = (state == WR_BURST);
    assign mem_cmd     = {2'b00, (state == RD_BURST)};
    assign mem_addr    = addr_q;
    assign mem_wr_data = wr_data;

    // Only the reader issues reads, so return data needs no steering.
    assign rd_valid    = mem_rd_valid;
    assign rd_data     = mem_rd_data;

endmodule

// File: tb/tb_graphic_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_graphic_mem_arbiter
//
// Self-checking bench for graphic_mem_arbiter: a per-cycle vector table for
// the basic read/write/wrap/single-beat cases, hand sequences for starvation,
// reset mid-burst and read passthrough, and a randomized run compared against
// a transaction-level model (queue of expected command addresses per burst).
// ---------------------------------------------------------------------------
module tb_graphic_mem_arbiter;

    localparam int ADDR_W     = 27;
    localparam int DATA_W     = 128;
    localparam int LEN_W      = 6;
    localparam int STARVE_MAX = 4;

    logic              hclk = 1'b0;
    logic              hreset;
    logic              rd_req, wr_req;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [LEN_W-1:0]  rd_len, wr_len;
    logic              rd_gnt, rd_done, rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt, wr_done, wr_data_ack;
    logic              mem_cmd_en;
    logic [2:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_cmd_rdy;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_rdy;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;

    int n_checks = 0;
    int n_errs   = 0;

    graphic_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .hclk(hclk), .hreset(hreset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_gnt(rd_gnt), .rd_done(rd_done), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
        .wr_gnt(wr_gnt), .wr_done(wr_done), .wr_data_ack(wr_data_ack),
        .mem_cmd_en(mem_cmd_en), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .mem_cmd_rdy(mem_cmd_rdy), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .mem_wr_rdy(mem_wr_rdy), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0;
        mem_cmd_rdy = 1; mem_wr_rdy = 1; mem_rd_valid = 0; mem_rd_data = '0; wr_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        hreset = 1;
        tick();
        tick();
        hreset = 0;
    endtask

    function automatic logic [DATA_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom) & 27'h7FFFFF8;
        if ($urandom_range(0, 5) == 0)
            a = 27'h7FFFFF8 - ADDR_W'(8 * $urandom_range(0, 3));
        return a;
    endfunction

    function automatic logic [LEN_W-1:0] rand_len();
        if ($urandom_range(0, 15) == 0) return 6'd63;
        return LEN_W'($urandom_range(0, 7));
    endfunction

    // -----------------------------------------------------------------------
    // Vector table: one record per cycle, applied in order after reset.
    // -----------------------------------------------------------------------
    typedef struct {
        logic              rd_req, wr_req;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic              cmd_rdy, wr_rdy;
        logic              e_rd_gnt, e_wr_gnt, e_cmd_en, e_wr_en;
        logic [2:0]        e_cmd;
        logic [ADDR_W-1:0] e_addr;
        logic              e_rd_done, e_wr_done;
    } vec_t;

    function automatic vec_t v(input logic rr, input logic wq, input logic [ADDR_W-1:0] a,
                               input logic [LEN_W-1:0] l, input logic cr, input logic wr,
                               input logic gr, input logic gw, input logic ce, input logic we,
                               input logic [2:0] c, input logic [ADDR_W-1:0] ea,
                               input logic dr, input logic dw);
        vec_t t;
        t.rd_req = rr; t.wr_req = wq; t.addr = a; t.len = l; t.cmd_rdy = cr; t.wr_rdy = wr;
        t.e_rd_gnt = gr; t.e_wr_gnt = gw; t.e_cmd_en = ce; t.e_wr_en = we;
        t.e_cmd = c; t.e_addr = ea; t.e_rd_done = dr; t.e_wr_done = dw;
        return t;
    endfunction

    // Transaction-level model state for the randomized run.
    int                m_kind;      // 0 none, 1 read burst, 2 write burst
    logic [ADDR_W-1:0] m_q[$];      // addresses still to be issued
    int                m_starve;

    initial begin
        vec_t vt[$];
        int   ack_cnt;

        // ---------------- reset state ----------------
        idle_inputs();
        hreset = 1;
        #2;
        check("reset_rd_gnt", rd_gnt, 0);
        check("reset_wr_gnt", wr_gnt, 0);
        check("reset_cmd_en", mem_cmd_en, 0);
        check("reset_wr_en", mem_wr_en, 0);
        check("reset_ack", wr_data_ack, 0);
        check("reset_cmd", mem_cmd, 3'b000);
        check("reset_addr", mem_addr, 0);
        check("reset_done", {rd_done, wr_done}, 2'b00);
        tick();
        tick();
        hreset = 0;

        // ---------------- vector table ----------------
        // read-only, len 3
        vt.push_back(v(1,0,27'h100,3,1,1, 0,0,0,0,3'b000,27'h0,0,0));
        vt.push_back(v(0,0,27'h0,0,1,1,   1,0,1,0,3'b001,27'h100,0,0));
        vt.push_back(v(0,0,27'h0,0,1,1,   1,0,1,0,3'b001,27'h108,0,0));
        vt.push_back(v(0,0,27'h0,0,1,1,   1,0,1,0,3'b001,27'h110,0,0));
        vt.push_back(v(0,0,27'h0,0,1,1,   1,0,1,0,3'b001,27'h118,1,0));
        vt.push_back(v(0,0,27'h0,0,1,1,   0,0,0,0,3'b000,27'h0,0,0));
        // write len 1 with wr_rdy low three cycles, then cmd_rdy low one cycle
        vt.push_back(v(0,1,27'h200,1,1,1, 0,0,0,0,3'b000,27'h0,0,0));
        vt.push_back(v(0,0,27'h0,0,1,1,   0,1,1,1,3'b000,27'h200,0,0));
        vt.push_back(v(0,0,27'h0,0,1,0,   0,1,0,0,3'b000,27'h208,0,0));
        vt.push_back(v(0,0,27'h0,0,1,0,   0,1,0,0,3'b000,27'h208,0,0));
        vt.push_back(v(0,0,27'h0,0,1,0,   0,1,0,0,3'b000,27'h208,0,0));
        vt.push_back(v(0,0,27'h0,0,0,1,   0,1,0,0,3'b000,27'h208,0,0));
        vt.push_back(v(0,0,27'h0,0,1,1,   0,1,1,1,3'b000,27'h208,0,1));
        vt.push_back(v(0,0,27'h0,0,1,1,   0,0,0,0,3'b000,27'h0,0,0));
        // wrap at top of memory, with one stalled command; a write request
        // raised mid-burst and dropped before IDLE must be ignored
        vt.push_back(v(1,0,27'h7FFFFF8,1,1,1, 0,0,0,0,3'b000,27'h0,0,0));
        vt.push_back(v(0,0,27'h0,0,0,1,   1,0,1,0,3'b001,27'h7FFFFF8,0,0));
        vt.push_back(v(0,1,27'h0,0,1,1,   1,0,1,0,3'b001,27'h7FFFFF8,0,0));
        vt.push_back(v(0,0,27'h0,0,1,1,   1,0,1,0,3'b001,27'h0,1,0));
        vt.push_back(v(0,0,27'h0,0,1,1,   0,0,0,0,3'b000,27'h0,0,0));
        vt.push_back(v(0,0,27'h0,0,1,1,   0,0,0,0,3'b000,27'h0,0,0));
        // single-beat read (len 0)
        vt.push_back(v(1,0,27'h40,0,1,1,  0,0,0,0,3'b000,27'h0,0,0));
        vt.push_back(v(0,0,27'h0,0,1,1,   1,0,1,0,3'b001,27'h40,1,0));
        vt.push_back(v(0,0,27'h0,0,1,1,   0,0,0,0,3'b000,27'h0,0,0));

        ack_cnt = 0;
        foreach (vt[i]) begin
            rd_req = vt[i].rd_req; wr_req = vt[i].wr_req;
            rd_addr = vt[i].addr; wr_addr = vt[i].addr;
            rd_len = vt[i].len; wr_len = vt[i].len;
            mem_cmd_rdy = vt[i].cmd_rdy; mem_wr_rdy = vt[i].wr_rdy;
            wr_data = rand128();
            #2;
            check($sformatf("vec%0d_rd_gnt", i), rd_gnt, vt[i].e_rd_gnt);
            check($sformatf("vec%0d_wr_gnt", i), wr_gnt, vt[i].e_wr_gnt);
            check($sformatf("vec%0d_cmd_en", i), mem_cmd_en, vt[i].e_cmd_en);
            check($sformatf("vec%0d_wr_en", i), mem_wr_en, vt[i].e_wr_en);
            check($sformatf("vec%0d_ack", i), wr_data_ack, vt[i].e_wr_en);
            check($sformatf("vec%0d_rd_done", i), rd_done, vt[i].e_rd_done);
            check($sformatf("vec%0d_wr_done", i), wr_done, vt[i].e_wr_done);
            if (vt[i].e_rd_gnt || vt[i].e_wr_gnt) begin
                check($sformatf("vec%0d_addr", i), mem_addr, vt[i].e_addr);
                check($sformatf("vec%0d_cmd", i), mem_cmd, vt[i].e_cmd);
            end
            if (wr_data_ack) ack_cnt++;
            tick();
        end
        check("table_ack_count", ack_cnt, 2);

        // ---------------- starvation ----------------
        do_reset();
        begin
            int       grants, last_done, bad_gap;
            logic [9:0] seq;
            logic     prev_gnt;
            grants = 0; last_done = -100; bad_gap = 0; seq = '0; prev_gnt = 0;
            rd_req = 1; wr_req = 1; rd_addr = 27'h1000; wr_addr = 27'h2000;
            rd_len = 0; wr_len = 0;
            for (int c = 0; c < 200 && grants < 10; c++) begin
                #2;
                if ((rd_gnt || wr_gnt) && !prev_gnt) begin
                    seq = {seq[8:0], wr_gnt};
                    grants++;
                    if (grants > 1 && c != last_done + 2) bad_gap++;
                end
                if (rd_done || wr_done) last_done = c;
                prev_gnt = rd_gnt || wr_gnt;
                tick();
            end
            check("starve_grant_count", grants, 10);
            check("starve_sequence", seq, 10'b0000100001);
            check("starve_done_to_grant_gap", bad_gap, 0);
            idle_inputs();
            tick(); tick(); tick();
        end

        // ---------------- reset mid-burst ----------------
        wr_req = 1; wr_addr = 27'h300; wr_len = 5;
        #2;
        check("rst_idle_gnt", wr_gnt, 0);
        tick();
        wr_req = 0;
        #2;
        check("rst_beat1_ack", wr_data_ack, 1);
        check("rst_beat1_addr", mem_addr, 27'h300);
        tick();
        #2;
        check("rst_beat2_gnt", wr_gnt, 1);
        check("rst_beat2_addr", mem_addr, 27'h308);
        #1 hreset = 1;
        #1;
        check("rst_async_wr_gnt", wr_gnt, 0);
        check("rst_async_cmd_en", mem_cmd_en, 0);
        check("rst_async_wr_en", mem_wr_en, 0);
        check("rst_async_ack", wr_data_ack, 0);
        check("rst_async_wr_done", wr_done, 0);
        check("rst_async_addr", mem_addr, 0);
        check("rst_async_cmd", mem_cmd, 0);
        tick();
        #2;
        check("rst_held_wr_done", wr_done, 0);
        check("rst_held_wr_gnt", wr_gnt, 0);
        tick();
        hreset = 0;
        rd_req = 1; rd_addr = 27'h500; rd_len = 0;
        #2;
        check("post_rst_idle", rd_gnt, 0);
        tick();
        rd_req = 0;
        #2;
        check("post_rst_rd_gnt", rd_gnt, 1);
        check("post_rst_addr", mem_addr, 27'h500);
        check("post_rst_cmd", mem_cmd, 3'b001);
        check("post_rst_rd_done", rd_done, 1);
        check("post_rst_no_wr_done", wr_done, 0);
        tick();

        // ---------------- read data passthrough during a write ----------------
        wr_req = 1; wr_addr = 27'h600; wr_len = 0; mem_wr_rdy = 0;
        #2;
        tick();
        wr_req = 0;
        wr_data = rand128();
        #2;
        check("pt_wr_gnt", wr_gnt, 1);
        check("pt_no_split_cmd", mem_cmd_en, 0);
        mem_rd_valid = 1; mem_rd_data = {4{32'hA5A5A5A5}};
        #1;
        check("pt_rd_valid", rd_valid, 1);
        check("pt_rd_data", rd_data, {4{32'hA5A5A5A5}});
        mem_wr_rdy = 1;
        #1;
        check("pt_wr_done", wr_done, 1);
        check("pt_wr_data", mem_wr_data, wr_data);
        mem_rd_valid = 0;
        #1;
        check("pt_rd_valid_low", rd_valid, 0);
        tick();

        // ---------------- randomized run against the model ----------------
        do_reset();
        m_kind = 0; m_q.delete(); m_starve = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic e_fire;
            rd_req = ($urandom_range(0, 3) != 0);
            wr_req = ($urandom_range(0, 3) != 0);
            rd_addr = rand_addr(); wr_addr = rand_addr();
            rd_len = rand_len();   wr_len = rand_len();
            mem_cmd_rdy = ($urandom_range(0, 3) != 0);
            mem_wr_rdy  = ($urandom_range(0, 3) != 0);
            mem_rd_valid = $urandom_range(0, 1);
            mem_rd_data = rand128();
            wr_data = rand128();
            #2;
            e_fire = (m_kind == 1) ? mem_cmd_rdy :
                     (m_kind == 2) ? (mem_cmd_rdy && mem_wr_rdy) : 1'b0;
            check("rnd_rd_gnt", rd_gnt, m_kind == 1);
            check("rnd_wr_gnt", wr_gnt, m_kind == 2);
            check("rnd_cmd_en", mem_cmd_en, (m_kind == 1) || (m_kind == 2 && e_fire));
            check("rnd_wr_en", mem_wr_en, m_kind == 2 && e_fire);
            check("rnd_ack", wr_data_ack, m_kind == 2 && e_fire);
            check("rnd_rd_done", rd_done, m_kind == 1 && e_fire && m_q.size() == 1);
            check("rnd_wr_done", wr_done, m_kind == 2 && e_fire && m_q.size() == 1);
            check("rnd_wr_data", mem_wr_data, wr_data);
            check("rnd_rd_valid", rd_valid, mem_rd_valid);
            check("rnd_rd_data", rd_data, mem_rd_data);
            if (m_kind != 0) begin
                check("rnd_addr", mem_addr, m_q[0]);
                check("rnd_cmd", mem_cmd, (m_kind == 1) ? 3'b001 : 3'b000);
            end

            // Advance the model across the clock edge.
            if (m_kind != 0) begin
                if (e_fire) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_kind = 0;
                end
            end else if (rd_req || wr_req) begin
                logic              take_wr;
                logic [ADDR_W-1:0] start;
                int                beats;
                take_wr = wr_req && (!rd_req || m_starve == STARVE_MAX);
                if (take_wr) begin
                    m_kind = 2; start = wr_addr; beats = int'(wr_len) + 1;
                    m_starve = 0;
                end else begin
                    m_kind = 1; start = rd_addr; beats = int'(rd_len) + 1;
                    if (wr_req && m_starve < STARVE_MAX) m_starve++;
                end
                for (int i = 0; i < beats; i++)
                    m_q.push_back(start + ADDR_W'(8 * i));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
